// File: rtl/data_frame_rx_pkg.sv
// Shared state encoding and error codes for the Aurora 3-word frame receiver.
package data_frame_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RECV    = 2'd1,
    ST_DISCARD = 2'd2
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_SHORT   = 2'b01;
  localparam logic [1:0] ERR_LONG    = 2'b10;
  localparam logic [1:0] ERR_KEEPGAP = 2'b11;

endpackage

// File: rtl/data_frame_rx_gap_timer.sv
// Counts consecutive idle cycles inside a frame; expire_o flags the GAP_MAX-th one.
module gap_timer #(
  parameter int unsigned GAP_MAX = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic tick_i,
  output logic expire_o
);

  localparam int unsigned W = $clog2(GAP_MAX + 1);

  logic [W-1:0] cnt_q;

  assign expire_o = tick_i && (cnt_q == W'(GAP_MAX - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      cnt_q <= '0;
    end else if (tick_i) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

endmodule

// File: rtl/data_frame_rx.sv
// Aurora RX user-data frame checker: validates length/keep/gap and latches good frames atomically.
module data_frame_rx
  import data_frame_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned KEEP_W  = 4,
  parameter int unsigned NWORDS  = 3,
  parameter int unsigned GAP_MAX = 255,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              clr_err,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  input  logic              rx_last,
  input  logic [KEEP_W-1:0] rx_keep,
  output logic [DATA_W-1:0] data_1,
  output logic [DATA_W-1:0] data_2,
  output logic [DATA_W-1:0] data_3,
  output logic              frame_done,
  output logic              frame_err,
  output logic [1:0]        err_code,
  output logic [CNT_W-1:0]  frame_count,
  output logic [CNT_W-1:0]  err_count,
  output logic              busy
);

  localparam int unsigned IDX_W = $clog2(NWORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]  shadow_q [NWORDS];
  logic [DATA_W-1:0]  frame_q  [3];
  logic               done_q, err_q, busy_q;
  logic [1:0]         code_q;
  logic [CNT_W-1:0]   fcnt_q, ecnt_q;

  logic               store, commit, err_ev, gap_expire, keep_ok;
  logic [1:0]         err_new;

  assign keep_ok = &rx_keep;

  gap_timer #(.GAP_MAX(GAP_MAX)) u_gap (
    .clk_i    (clk),
    .rst_i    (reset),
    .clear_i  ((state_q != ST_RECV) || rx_valid),
    .tick_i   ((state_q == ST_RECV) && !rx_valid),
    .expire_o (gap_expire)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    store   = 1'b0;
    commit  = 1'b0;
    err_ev  = 1'b0;
    err_new = ERR_NONE;
    unique case (state_q)
      ST_IDLE: begin
        if (rx_valid && en) begin
          store = 1'b1;
          if (!keep_ok) begin
            err_ev  = 1'b1;
            err_new = ERR_KEEPGAP;
            state_d = rx_last ? ST_IDLE : ST_DISCARD;
          end else if (rx_last) begin
            err_ev  = 1'b1;
            err_new = ERR_SHORT;
          end else begin
            state_d = ST_RECV;
            idx_d   = IDX_W'(1);
          end
        end else if (rx_valid && !rx_last) begin
          state_d = ST_DISCARD;
        end
      end
      ST_RECV: begin
        if (rx_valid) begin
          store = 1'b1;
          idx_d = '0;
          if (!keep_ok) begin
            err_ev  = 1'b1;
            err_new = ERR_KEEPGAP;
            state_d = rx_last ? ST_IDLE : ST_DISCARD;
          end else if (idx_q == LAST_IDX) begin
            if (rx_last) begin
              commit  = 1'b1;
              state_d = ST_IDLE;
            end else begin
              err_ev  = 1'b1;
              err_new = ERR_LONG;
              state_d = ST_DISCARD;
            end
          end else if (rx_last) begin
            err_ev  = 1'b1;
            err_new = ERR_SHORT;
            state_d = ST_IDLE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else if (gap_expire) begin
          err_ev  = 1'b1;
          err_new = ERR_KEEPGAP;
          state_d = ST_IDLE;
          idx_d   = '0;
        end
      end
      ST_DISCARD: begin
        if (rx_valid && rx_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      code_q  <= ERR_NONE;
      fcnt_q  <= '0;
      ecnt_q  <= '0;
      for (int unsigned i = 0; i < NWORDS; i++) shadow_q[i] <= '0;
      for (int unsigned i = 0; i < 3; i++) frame_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= commit;
      if (store) shadow_q[idx_q] <= rx_data;
      // Final word bypasses the shadow so the whole frame lands on the same edge.
      if (commit) begin
        fcnt_q <= fcnt_q + CNT_W'(1);
        for (int unsigned i = 0; i < 3; i++) begin
          if (i + 1 < NWORDS)       frame_q[i] <= shadow_q[i];
          else if (i + 1 == NWORDS) frame_q[i] <= rx_data;
        end
      end
      if (err_ev) begin
        err_q  <= 1'b1;
        ecnt_q <= ecnt_q + CNT_W'(1);
        if (clr_err || code_q == ERR_NONE) code_q <= err_new;
      end else if (clr_err) begin
        err_q  <= 1'b0;
        code_q <= ERR_NONE;
      end
    end
  end

  assign data_1      = frame_q[0];
  assign data_2      = frame_q[1];
  assign data_3      = frame_q[2];
  assign frame_done  = done_q;
  assign frame_err   = err_q;
  assign err_code    = code_q;
  assign frame_count = fcnt_q;
  assign err_count   = ecnt_q;
  assign busy        = busy_q;

endmodule
